gate_result_checker: RTL

GATE_RESULT_CHECKER -- requirements
Module: gate_result_checker

---
 rtl/gate_result_checker_pkg.sv | 17 +
 rtl/and16.sv | 12 +
 rtl/gate_ref16.sv | 17 +
 rtl/not16.sv | 11 +
 rtl/or16.sv | 12 +
 rtl/gate_result_checker.sv | 156 +++++++++++++++
 6 files changed

// File: rtl/gate_result_checker_pkg.sv
// Shared definitions for the gate result checker: FSM state encoding and
// the bit positions of the per-gate mismatch flags.
package gate_result_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int FM_NOT = 0;
  localparam int FM_AND = 1;
  localparam int FM_OR  = 2;
  localparam int FM_W   = 3;

endpackage

// File: rtl/and16.sv
// Bitwise AND used as the golden AND reference.
module and16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = a & b;

endmodule

// File: rtl/gate_ref16.sv
// Combinational expected-value generator: golden NOT/AND/OR of the operands,
// built from the reference gate primitives.
module gate_ref16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] exp_not,
  output logic [W-1:0] exp_and,
  output logic [W-1:0] exp_or
);

  not16 #(.W(W)) u_not (.a(a), .y(exp_not));
  and16 #(.W(W)) u_and (.a(a), .b(b), .y(exp_and));
  or16  #(.W(W)) u_or  (.a(a), .b(b), .y(exp_or));

endmodule

// File: rtl/not16.sv
// Bitwise inverter used as the golden NOT reference.
module not16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  output logic [W-1:0] y
);

  assign y = ~a;

endmodule

// File: rtl/or16.sv
// Bitwise OR used as the golden OR reference.
module or16 #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = a | b;

endmodule

// File: rtl/gate_result_checker.sv
// Streams operand/observed-output vectors through a one-deep compare stage,
// counts checked and failing vectors, and records the first failure.
module gate_result_checker
  import gate_result_checker_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [CW-1:0]   num_vectors,
  // Handshake: a vector moves in on any rising edge where in_valid && in_ready.
  // in_ready depends only on state, never on in_valid.
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  input  logic [W-1:0]    not_in,
  input  logic [W-1:0]    and_in,
  input  logic [W-1:0]    or_in,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [CW-1:0]   chk_count,
  output logic [CW-1:0]   err_count,
  output logic [W-1:0]    fail_a,
  output logic [W-1:0]    fail_b,
  output logic [FM_W-1:0] fail_mask,
  output logic [1:0]      dbg_state
);

  state_e          r_state;
  state_e          w_next_state;
  logic [CW-1:0]   r_num;
  logic [CW-1:0]   r_acc_cnt;
  logic            r_stg_valid;
  logic [W-1:0]    r_stg_a;
  logic [W-1:0]    r_stg_b;
  logic [W-1:0]    r_stg_not;
  logic [W-1:0]    r_stg_and;
  logic [W-1:0]    r_stg_or;
  logic [CW-1:0]   r_chk;
  logic [CW-1:0]   r_err;
  logic [W-1:0]    r_fail_a;
  logic [W-1:0]    r_fail_b;
  logic [FM_W-1:0] r_fail_mask;

  logic            w_in_ready;
  logic            w_xfer;
  logic            w_start_acc;
  logic            w_last_xfer;
  logic [W-1:0]    w_exp_not;
  logic [W-1:0]    w_exp_and;
  logic [W-1:0]    w_exp_or;
  logic [FM_W-1:0] w_mismatch;

  assign w_in_ready  = (r_state == ST_RUN);
  assign w_xfer      = in_valid && w_in_ready;
  assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_last_xfer = w_xfer && ((r_acc_cnt + CW'(1)) == r_num);

  gate_ref16 #(.W(W)) u_ref (
    .a       (r_stg_a),
    .b       (r_stg_b),
    .exp_not (w_exp_not),
    .exp_and (w_exp_and),
    .exp_or  (w_exp_or)
  );

  always_comb begin
    w_mismatch         = '0;
    w_mismatch[FM_NOT] = |(r_stg_not ^ w_exp_not);
    w_mismatch[FM_AND] = |(r_stg_and ^ w_exp_and);
    w_mismatch[FM_OR]  = |(r_stg_or  ^ w_exp_or);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // DRAIN is only ever entered with the last vector in the compare stage,
  // and that vector retires on the very next edge.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_next_state = (num_vectors == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN:   if (w_last_xfer) w_next_state = ST_DRAIN;
      ST_DRAIN: w_next_state = ST_DONE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num       <= '0;
      r_acc_cnt   <= '0;
      r_stg_valid <= 1'b0;
      r_stg_a     <= '0;
      r_stg_b     <= '0;
      r_stg_not   <= '0;
      r_stg_and   <= '0;
      r_stg_or    <= '0;
      r_chk       <= '0;
      r_err       <= '0;
      r_fail_a    <= '0;
      r_fail_b    <= '0;
      r_fail_mask <= '0;
    end else if (w_start_acc) begin
      r_num       <= num_vectors;
      r_acc_cnt   <= '0;
      r_stg_valid <= 1'b0;
      r_chk       <= '0;
      r_err       <= '0;
      r_fail_a    <= '0;
      r_fail_b    <= '0;
      r_fail_mask <= '0;
    end else begin
      r_stg_valid <= w_xfer;
      if (w_xfer) begin
        r_acc_cnt <= r_acc_cnt + CW'(1);
        r_stg_a   <= a;
        r_stg_b   <= b;
        r_stg_not <= not_in;
        r_stg_and <= and_in;
        r_stg_or  <= or_in;
      end
      if (r_stg_valid) begin
        r_chk <= r_chk + CW'(1);
        if (|w_mismatch) begin
          if (r_err != '1) r_err <= r_err + CW'(1);
          if (r_err == '0) begin
            r_fail_a    <= r_stg_a;
            r_fail_b    <= r_stg_b;
            r_fail_mask <= w_mismatch;
          end
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);
  assign pass      = done && (r_err == '0);
  assign chk_count = r_chk;
  assign err_count = r_err;
  assign fail_a    = r_fail_a;
  assign fail_b    = r_fail_b;
  assign fail_mask = r_fail_mask;
  assign dbg_state = r_state;

endmodule
